// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the UART write port.
// master: the requester/UART side that drives rValid/rByte/rLast/uCanWrite.
// slave:  the arbiter that drives rReady, the UART write strobe and the status.
// Handshake: a lane byte moves on a cycle where rValid[i] && rReady[i] are
// both high. rReady is never set for a lane without rValid. The requester
// holds rByte/rLast stable while rValid && !rReady. uWrite pushes one byte per
// asserted cycle and is only raised while uCanWrite is high.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   rValid;
    logic [8*N_REQ-1:0] rByte;
    logic [N_REQ-1:0]   rLast;
    logic [N_REQ-1:0]   rReady;
    logic [7:0]         uByte;
    logic               uWrite;
    logic               uCanWrite;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [7:0]         aborts;
    logic [1:0]         state_dbg;

    modport master (
        output rValid, rByte, rLast, uCanWrite,
        input  rReady, uByte, uWrite, grant, busy, aborts, state_dbg
    );

    modport slave (
        input  rValid, rByte, rLast, uCanWrite,
        output rReady, uByte, uWrite, grant, busy, aborts, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmit port between
// N_REQ byte-stream requesters. A lane keeps the UART until it sends a byte
// flagged last or stalls for TIMEOUT cycles inside its packet.
// Optional macro UART_ARB_TAG_EN: emit a header byte 0xF0|lane after each grant.
module uart_tx_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input logic             clock,
    input logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef UART_ARB_TAG_EN
    localparam logic [1:0] ST_TAG  = 2'd2;
`endif

    logic [1:0]       state;
    logic [N_REQ-1:0] grant_q;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       aborts_q;

    logic [PTR_W-1:0] pick;
    logic             found;
    logic             cur_valid;
    logic             cur_last;
    logic [7:0]       cur_byte;
    logic             xfer;

    // Round-robin scan: first requesting lane after the pointer wins
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && bus.rValid[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    // Select the granted lane's request signals
    always_comb begin
        cur_valid = bus.rValid[gidx];
        cur_last  = bus.rLast[gidx];
        cur_byte  = bus.rByte[int'(gidx)*8 +: 8];
    end

    // UART write port and lane ready, purely from the registered grant
    always_comb begin
        xfer       = 1'b0;
        bus.uWrite = 1'b0;
        bus.uByte  = '0;
        bus.rReady = '0;
        case (state)
            ST_SEND: begin
                xfer       = cur_valid && bus.uCanWrite;
                bus.uWrite = xfer;
                bus.uByte  = cur_byte;
                bus.rReady = xfer ? grant_q : '0;
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                bus.uWrite = bus.uCanWrite;
                bus.uByte  = 8'hF0 | 8'(gidx);
            end
`endif
            default: ;
        endcase
    end

    // Status outputs
    always_comb begin
        bus.grant     = grant_q;
        bus.busy      = (state != ST_IDLE);
        bus.aborts    = aborts_q;
        bus.state_dbg = state;
    end

    // Grant FSM, round-robin pointer, stall timeout and abort counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            gidx     <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            cnt      <= '0;
            aborts_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_q <= N_REQ'(1) << pick;
                        gidx    <= pick;
                        cnt     <= '0;
`ifdef UART_ARB_TAG_EN
                        state   <= ST_TAG;
`else
                        state   <= ST_SEND;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_TAG: begin
                    if (bus.uCanWrite) begin
                        state <= ST_SEND;
                    end
                end
`endif
                ST_SEND: begin
                    if (xfer && cur_last) begin
                        ptr     <= gidx;
                        grant_q <= '0;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else if (cur_valid) begin
                        // UART back-pressure is not a requester stall
                        cnt <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This idle cycle is the TIMEOUT-th in a row
                        ptr     <= gidx;
                        grant_q <= '0;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                        if (aborts_q != 8'hFF) begin
                            aborts_q <= aborts_q + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule
